// File: rtl/mdu_scheduler.sv
// Multi-cycle MIPS multiply/divide unit with HI/LO registers and busy sequencing.
// Latency: MULT_CYCLES or DIV_CYCLES busy cycles; stall_req combinationally holds MDU users in D.
module mdu_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        hi_nxt_q, hi_nxt_d, lo_nxt_q, lo_nxt_d;

  logic [63:0] prod_s, prod_u;
  logic        div_signed, a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  // The 64-bit product of sign-extended operands is exact modulo 2^64.
  assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign prod_u = {32'b0, rs_val} * {32'b0, rt_val};

  // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign div_signed = (mdu_op == 3'd2);
  assign a_neg      = div_signed & rs_val[31];
  assign b_neg      = div_signed & rt_val[31];
  assign a_mag      = a_neg ? -rs_val : rs_val;
  assign b_mag      = b_neg ? -rt_val : rt_val;
  assign div_zero   = (rt_val == 32'd0);
  assign b_safe     = div_zero ? 32'd1 : b_mag;
  assign q_mag      = a_mag / b_safe;
  assign r_mag      = a_mag % b_safe;
  assign quot       = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem        = a_neg ? -r_mag : r_mag;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_nxt_d = hi_nxt_q;
    lo_nxt_d = lo_nxt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (mdu_op)
            3'd0: begin
              {hi_nxt_d, lo_nxt_d} = prod_s;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = RUN;
            end
            3'd1: begin
              {hi_nxt_d, lo_nxt_d} = prod_u;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = RUN;
            end
            3'd2, 3'd3: begin
              // Divide by zero still occupies the unit but leaves HI/LO as they were.
              hi_nxt_d = div_zero ? hi_q : rem;
              lo_nxt_d = div_zero ? lo_q : quot;
              cnt_d    = CNT_W'(DIV_CYCLES);
              state_d  = RUN;
            end
            3'd4:    hi_d = rs_val;
            3'd5:    lo_d = rs_val;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = hi_nxt_q;
          lo_d    = lo_nxt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_nxt_q <= '0;
      lo_nxt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_nxt_q <= hi_nxt_d;
      lo_nxt_q <= lo_nxt_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign stall_req = d_md_use & (busy | (start & (mdu_op <= 3'd3)));
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: doc/mdu_scheduler.md
Name: mdu_scheduler

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers and its sequencing controller for the 5-stage MIPS pipeline.
- Sits in the E stage. Accepts mult/div/mthi/mtlo from E and models the multi-cycle latency with a busy counter.
- Produces the stall request that the hazard unit uses to freeze D when an MDU-dependent instruction (mult/div/mfhi/mflo/mthi/mtlo) arrives while the unit is occupied.

Parameters:
- MULT_CYCLES, 5: busy cycles for MULT/MULTU (>=1).
- DIV_CYCLES, 10: busy cycles for DIV/DIVU (>=1).
- CNT_W, 4: counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  E-stage MDU operation valid this cycle.
- mdu_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved (no-op).
- rs_val  input  32  operand A / MTHI-MTLO source.
- rt_val  input  32  operand B.
- d_md_use  input  1  D-stage instruction is any MDU instruction (incl. MFHI/MFLO).
- busy  output  1  registered; unit executing a mult/div.
- stall_req  output  1  combinational: d_md_use & (busy | (start & mdu_op<=3)).
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Single clock domain; all state updates on the rising edge of clk.
- Reset (synchronous, dominates all inputs):
  - busy=0, hi=0, lo=0, counter=0, state=IDLE.
  - Any pending result is discarded, including mid-operation.
- States:
  - IDLE: busy=0.
    - start with op 0-3: latch result into internal hi_nxt/lo_nxt, load counter with MULT_CYCLES or DIV_CYCLES, go to RUN.
    - start with op 4: hi<=rs_val at that edge, stay IDLE, busy stays 0.
    - start with op 5: lo<=rs_val at that edge, stay IDLE, busy stays 0.
    - start with op 6-7: ignored.
  - RUN: busy=1. Counter decrements every cycle. At the edge where counter==1: hi<=hi_nxt, lo<=lo_nxt, busy<=0, go to IDLE.
- Timing: start sampled at edge k gives busy=1 from edge k to edge k+N, with new HI/LO visible after edge k+N (N = op latency).
- start while busy=1: ignored; no state, counter or HI/LO change. The pipeline must stall it, and the bench asserts start&busy never occurs in system tests.
- start at the same edge busy falls: busy is still 1 at that edge, so start is ignored.
- hi/lo outputs are unaffected during RUN and show old values until completion.
- Arithmetic:
  - MULT: signed 32x32 -> 64, {hi,lo}=product.
  - MULTU: unsigned 32x32 -> 64.
  - DIV: signed. lo=quotient truncated toward zero. hi=remainder with the sign of the dividend.
  - DIVU: unsigned. lo=quotient, hi=remainder.
  - Divide by zero: full DIV_CYCLES busy period; hi/lo unchanged at completion.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- stall_req is combinational, with no register stage. It is asserted the same cycle start issues a mult/div, so a following MDU instruction in D is held.
- Non-MDU instructions in D are never stalled by this block.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFE (-2), rt=3 -> busy high for 5 cycles; after edge k+5, hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy=0.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 cycles, hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=7, rt=0 with prior hi=0x11, lo=0x22 -> busy 10 cycles; hi/lo stay 0x11/0x22.
- MTHI rs=0xABCD0000 in IDLE -> hi=0xABCD0000 next cycle, busy never asserts. Then DIV issued with d_md_use=1 held -> stall_req=1 on the issue cycle and all 10 busy cycles, 0 afterwards; stall_req=0 whenever d_md_use=0.
- DIV started, reset pulsed at busy cycle 4 -> next edge busy=0, hi=lo=0; no late write afterwards. Also: start pulsed mid-RUN with MULT -> ignored, original DIV result written at the originally scheduled edge.
